miner_host_link: RTL and testbench
==================================

Name: miner_host_link

Overview:
Host-side counterpart of the accelerator's UART framing, acting as the initiator end of the link. It serializes a 608-bit block header into 76 bytes for the existing uart_tx byte interface. It then collects the 16-byte nonce reply from uart_rx and majority-decodes the 4 redundant copies of each nonce byte into a 32-bit nonce. It is used as the bench/loopback host and as the upstream controller when accelerators are chained.

Parameters:
BLOCK_BYTES, 76, header bytes sent per job (block_i width = 8*BLOCK_BYTES)
NONCE_COPIES, 4, redundant copies of each nonce byte in the reply (reply = 4*NONCE_COPIES bytes)
TIMEOUT_CYCLES, 2_000_000, max idle clk cycles between reply bytes before abort

Ports:
clk  input  1  system clock
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  pulse: begin a job; ignored while busy_o=1
block_i  input  608  header; sampled on the accepted start_i cycle
tx_byte_o  output  8  byte to uart_tx i_Tx_Byte
tx_dv_o  output  1  1-cycle strobe to uart_tx i_Tx_DV
tx_active_i  input  1  uart_tx o_Tx_Active
tx_done_i  input  1  uart_tx o_Tx_Done
rx_dv_i  input  1  uart_rx o_Rx_DV, 1-cycle
rx_byte_i  input  8  uart_rx o_Rx_Byte
busy_o  output  1  job in progress
done_o  output  1  1-cycle pulse: reply decoded successfully
nonce_o  output  32  decoded nonce; held until next done_o
corrected_o  output  1  last decode outvoted at least one copy
err_mismatch_o  output  1  sticky: some byte group had no 3-of-4 majority
err_timeout_o  output  1  sticky: reply byte gap exceeded TIMEOUT_CYCLES

Behaviour:
- Reset (rst_i=0, async): state IDLE; all outputs 0; counters and shift registers cleared. tx_dv_o drops immediately, even mid-byte.
- States: IDLE, SEND, WAIT_TX, RECV, CHECK, DONE.
- IDLE: start_i=1 latches block_i into a shift register, clears both err flags and corrected_o, sets busy_o, and moves to SEND.
- SEND: if tx_active_i=0, pulse tx_dv_o for exactly 1 cycle with tx_byte_o = byte k (k = 0..75), then go to WAIT_TX. Byte k = block_i[8k+7:8k], LSB byte first. tx_byte_o is stable from the strobe cycle until tx_done_i.
- First tx_dv_o is asserted in the cycle after start_i is accepted.
- WAIT_TX: on tx_done_i, increment byte count. Count == BLOCK_BYTES: clear reply count and timeout counter, go to RECV. Otherwise go to SEND (1-cycle gap minimum).
- RECV: each rx_dv_i stores rx_byte_i as reply byte j (j = 0..15) and resets the timeout counter. The timeout counter otherwise increments every cycle.
  - Reply layout: byte j = copy (j mod 4) of nonce byte floor(j/4). Nonce byte 0 (bits 7:0) arrives first.
  - After byte 15, go to CHECK.
  - Timeout counter reaching TIMEOUT_CYCLES sets err_timeout_o and returns to IDLE. done_o stays 0 and nonce_o is unchanged.
- rx_dv_i outside RECV is discarded. This covers stale bytes received while sending.
- CHECK (1 cycle), per group of 4 copies:
  - 4 equal: use that value.
  - Exactly 3 equal: use the majority value and set corrected_o.
  - Otherwise: the group fails.
  - Any failed group sets err_mismatch_o and returns to IDLE without done_o; nonce_o is unchanged.
- DONE (1 cycle): nonce_o updated, done_o=1, then IDLE with busy_o=0.
- Latency: done_o is high in the 2nd cycle after the edge sampling the 16th rx_dv_i.
- start_i while busy is ignored. start_i in the same cycle as DONE is also ignored; it is accepted only in IDLE.
- Widths: byte counter 7 bits, reply counter 5 bits, timeout counter sized as $clog2(TIMEOUT_CYCLES+1).
- No arithmetic wrap anywhere: counters are cleared before each phase.

Test Plan:
- Reset/idle: hold rst_i=0 then release → all outputs 0. start_i pulse with block_i = {76 bytes 0x00..0x4B} → tx_byte_o sequence 0x00,0x01,...,0x4B, one tx_dv_o per tx_done_i, exactly 76 strobes, busy_o=1 throughout.
- Clean reply: after the send phase, feed 16 bytes EF×4, BE×4, AD×4, DE×4 → done_o pulse, nonce_o=0xDEADBEEF, corrected_o=0, both err=0, busy_o falls the same cycle done_o rises.
- Single corruption: copies of byte 2 are AD,AD,00,AD → nonce_o=0xDEADBEEF, corrected_o=1, done_o=1.
- Mismatch: byte 1 copies BE,BE,00,11 → err_mismatch_o=1, no done_o, nonce_o keeps its previous value, next start_i clears the flag.
- Timeout and noise: TIMEOUT_CYCLES=100 with only 5 reply bytes sent → err_timeout_o=1 at the 100th idle cycle, state IDLE. rx_dv_i pulses injected during the send phase → ignored, reply still decodes correctly.
- Reset mid-job: assert rst_i=0 after 30 header bytes → tx_dv_o/busy_o=0 asynchronously. A new start_i then sends from byte 0.

Source files
------------

// File: rtl/miner_host_link.sv
`default_nettype none
// ============================================================================
// Module      : miner_host_link
// Description : Initiator end of the accelerator UART link. Streams a block
//               header out byte-by-byte through a uart_tx byte interface,
//               then collects the redundant nonce reply from uart_rx and
//               majority-decodes it into a 32-bit nonce.
// Revision    : 1.0 - initial release
// ============================================================================
module miner_host_link #(
    parameter int BLOCK_BYTES    = 76,
    parameter int NONCE_COPIES   = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [8*BLOCK_BYTES-1:0] block_i,
    output logic [7:0]               tx_byte_o,
    output logic                     tx_dv_o,
    input  logic                     tx_active_i,
    input  logic                     tx_done_i,
    input  logic                     rx_dv_i,
    input  logic [7:0]               rx_byte_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [31:0]              nonce_o,
    output logic                     corrected_o,
    output logic                     err_mismatch_o,
    output logic                     err_timeout_o
);

    localparam int              c_REPLY_BYTES = 4 * NONCE_COPIES;
    localparam int              c_TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0]      c_LAST_TX     = 7'(BLOCK_BYTES - 1);
    localparam logic [4:0]      c_LAST_RX     = 5'(c_REPLY_BYTES - 1);
    localparam logic [c_TW-1:0] c_TO_LAST     = c_TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_WAIT_TX = 3'd2,
        S_RECV    = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [8*BLOCK_BYTES-1:0]       r_shift;
    logic [6:0]                     r_byte_cnt;
    logic [4:0]                     r_rx_cnt;
    logic [c_TW-1:0]                r_to_cnt;
    logic [8*c_REPLY_BYTES-1:0]     r_reply;
    logic [31:0]                    r_nonce;
    logic                           r_corrected;
    logic                           r_err_mismatch;
    logic                           r_err_timeout;

    logic                           w_tx_last;
    logic                           w_rx_last;
    logic                           w_to_hit;
    logic [3:0]                     w_grp_ok;
    logic [3:0]                     w_grp_corr;
    logic [31:0]                    w_dec_nonce;

    // Vote over the copies of one nonce byte: returns {ok, corrected, value}.
    // A value held by all copies is clean, one held by all but one copy is a
    // correction, anything weaker fails the group.
    function automatic logic [9:0] vote(input logic [8*NONCE_COPIES-1:0] grp);
        int         best;
        int         cnt;
        logic [7:0] val;
        best = 0;
        val  = '0;
        for (int i = 0; i < NONCE_COPIES; i++) begin
            cnt = 0;
            for (int k = 0; k < NONCE_COPIES; k++) begin
                if (grp[8*k +: 8] == grp[8*i +: 8]) cnt++;
            end
            if (cnt > best) begin
                best = cnt;
                val  = grp[8*i +: 8];
            end
        end
        vote = {(best >= NONCE_COPIES - 1), (best == NONCE_COPIES - 1), val};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_vote
        assign {w_grp_ok[g], w_grp_corr[g], w_dec_nonce[8*g +: 8]} =
            vote(r_reply[g*8*NONCE_COPIES +: 8*NONCE_COPIES]);
    end

    assign w_tx_last      = (r_byte_cnt == c_LAST_TX);
    assign w_rx_last      = (r_rx_cnt == c_LAST_RX);
    assign w_to_hit       = (r_to_cnt == c_TO_LAST);
    assign tx_byte_o      = r_shift[7:0];
    assign nonce_o        = r_nonce;
    assign corrected_o    = r_corrected;
    assign err_mismatch_o = r_err_mismatch;
    assign err_timeout_o  = r_err_timeout;

    // State register; async reset forces IDLE so tx_dv_o drops at once.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and state-decoded strobes.
    always_comb begin
        w_next  = r_state;
        tx_dv_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next = S_SEND;
            end
            S_SEND: begin
                busy_o = 1'b1;
                if (!tx_active_i) begin
                    tx_dv_o = 1'b1;
                    w_next  = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                busy_o = 1'b1;
                if (tx_done_i) w_next = w_tx_last ? S_RECV : S_SEND;
            end
            S_RECV: begin
                busy_o = 1'b1;
                if (rx_dv_i) begin
                    if (w_rx_last) w_next = S_CHECK;
                end else if (w_to_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_CHECK: begin
                busy_o = 1'b1;
                w_next = (&w_grp_ok) ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: header shifter, counters, reply capture and result flags.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_shift        <= '0;
            r_byte_cnt     <= '0;
            r_rx_cnt       <= '0;
            r_to_cnt       <= '0;
            r_reply        <= '0;
            r_nonce        <= '0;
            r_corrected    <= 1'b0;
            r_err_mismatch <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_shift        <= block_i;
                        r_byte_cnt     <= '0;
                        r_corrected    <= 1'b0;
                        r_err_mismatch <= 1'b0;
                        r_err_timeout  <= 1'b0;
                    end
                end
                S_WAIT_TX: begin
                    // Shift only once the byte is on the wire so tx_byte_o
                    // stays valid for the whole uart_tx transfer.
                    if (tx_done_i) begin
                        r_shift    <= r_shift >> 8;
                        r_byte_cnt <= r_byte_cnt + 7'd1;
                        if (w_tx_last) begin
                            r_rx_cnt <= '0;
                            r_to_cnt <= '0;
                        end
                    end
                end
                S_RECV: begin
                    if (rx_dv_i) begin
                        r_reply[{r_rx_cnt, 3'b000} +: 8] <= rx_byte_i;
                        r_rx_cnt <= r_rx_cnt + 5'd1;
                        r_to_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_corrected <= |w_grp_corr;
                    if (&w_grp_ok) r_nonce        <= w_dec_nonce;
                    else           r_err_mismatch <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miner_host_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_miner_host_link
// Description : Self-checking bench for miner_host_link with a uart_tx
//               responder, random headers and a majority-vote reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miner_host_link;

    localparam int BB = 76;
    localparam int NC = 4;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [8*BB-1:0] block_i;
    logic [7:0]      tx_byte_o;
    logic            tx_dv_o;
    logic            tx_active_i;
    logic            tx_done_i;
    logic            rx_dv_i;
    logic [7:0]      rx_byte_i;
    logic            busy_o;
    logic            done_o;
    logic [31:0]     nonce_o;
    logic            corrected_o;
    logic            err_mismatch_o;
    logic            err_timeout_o;

    int          errors = 0;
    int          checks = 0;
    int          dv_cnt = 0;
    bit          resp_busy = 1'b0;
    logic [7:0]  sent_q[$];
    logic [31:0] exp_nonce = 32'd0;
    logic [7:0]  rep[16];
    logic [8*BB-1:0] blk;

    miner_host_link #(
        .BLOCK_BYTES   (BB),
        .NONCE_COPIES  (NC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .block_i       (block_i),
        .tx_byte_o     (tx_byte_o),
        .tx_dv_o       (tx_dv_o),
        .tx_active_i   (tx_active_i),
        .tx_done_i     (tx_done_i),
        .rx_dv_i       (rx_dv_i),
        .rx_byte_i     (rx_byte_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .nonce_o       (nonce_o),
        .corrected_o   (corrected_o),
        .err_mismatch_o(err_mismatch_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_dv_o === 1'b1) dv_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // uart_tx stand-in: busy for a few cycles after each strobe, then done.
    initial begin
        logic [7:0] held;
        tx_active_i = 1'b0;
        tx_done_i   = 1'b0;
        forever begin
            if (tx_dv_o === 1'b1 && rst_i === 1'b1) begin
                resp_busy = 1'b1;
                held = tx_byte_o;
                sent_q.push_back(held);
                @(negedge clk);
                tx_active_i = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (rst_i && busy_o) chk("tx_byte_stable", 64'(tx_byte_o), 64'(held));
                tx_done_i   = 1'b1;
                tx_active_i = 1'b0;
                @(negedge clk);
                tx_done_i = 1'b0;
                resp_busy = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Reference decode: a group's value must be shared by at least 3 of its
    // 4 copies; such a value is necessarily copy 0 or copy 1.
    task automatic ref_decode(input logic [7:0] r[16], output bit ok, output bit corr,
                              output logic [31:0] n);
        ok = 1'b1; corr = 1'b0; n = '0;
        for (int g = 0; g < 4; g++) begin
            bit found = 1'b0;
            for (int cand = 0; cand < 2; cand++) begin
                int m = 0;
                for (int i = 0; i < 4; i++) if (r[4*g+i] == r[4*g+cand]) m++;
                if (!found && m >= 3) begin
                    found = 1'b1;
                    n[8*g +: 8] = r[4*g+cand];
                    if (m == 3) corr = 1'b1;
                end
            end
            if (!found) ok = 1'b0;
        end
    endtask

    task automatic mk_reply(input logic [31:0] n, output logic [7:0] r[16]);
        for (int j = 0; j < 16; j++) r[j] = n[8*(j/4) +: 8];
    endtask

    function automatic logic [8*BB-1:0] rand_block();
        logic [8*BB-1:0] b;
        for (int w = 0; w < BB/4; w++) b[32*w +: 32] = $urandom;
        return b;
    endfunction

    task automatic do_send(input logic [8*BB-1:0] b, input bit noise, input bit glitch);
        int c = 0;
        bit busy_ok = 1'b1;
        while ((resp_busy || busy_o) && c < 200) begin @(negedge clk); c++; end
        sent_q.delete();
        dv_cnt  = 0;
        start_i = 1'b1;
        block_i = b;
        @(negedge clk);
        start_i = 1'b0;
        chk("first_dv", 64'(tx_dv_o), 64'd1);
        chk("busy_rise", 64'(busy_o), 64'd1);
        chk("flags_cleared", 64'({corrected_o, err_mismatch_o, err_timeout_o}), 64'd0);
        c = 0;
        while (!(sent_q.size() == BB && !resp_busy) && c < 5000) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk);
            c++;
            rx_dv_i = 1'b0;
            start_i = 1'b0;
            block_i = b;
            if (noise && sent_q.size() < BB && $urandom_range(0, 5) == 0) begin
                rx_dv_i   = 1'b1;
                rx_byte_i = 8'($urandom);
            end
            if (glitch && sent_q.size() == 10) begin
                start_i = 1'b1;
                block_i = ~b;
            end
        end
        rx_dv_i = 1'b0;
        start_i = 1'b0;
        chk("send_bound", 64'(c < 5000), 64'd1);
        chk("busy_during_send", 64'(busy_ok), 64'd1);
        chk("strobe_count", 64'(dv_cnt), 64'(BB));
        chk("sent_count", 64'(sent_q.size()), 64'(BB));
        for (int k = 0; k < BB; k++) begin
            logic [7:0] got = (k < sent_q.size()) ? sent_q[k] : 8'hxx;
            chk($sformatf("tx_byte[%0d]", k), 64'(got), 64'(b[8*k +: 8]));
        end
        chk("busy_in_recv", 64'(busy_o), 64'd1);
    endtask

    task automatic send_reply(input logic [7:0] r[16], input int n);
        for (int j = 0; j < n; j++) begin
            rx_dv_i   = 1'b1;
            rx_byte_i = r[j];
            @(negedge clk);
            rx_dv_i   = 1'b0;
            rx_byte_i = 8'($urandom);
            if (j != n - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // Called in the CHECK cycle (one negedge after the last reply byte).
    task automatic check_result(input logic [7:0] r[16], input bit late_start);
        bit ok, corr;
        logic [31:0] n;
        ref_decode(r, ok, corr, n);
        chk("done_low_in_check", 64'(done_o), 64'd0);
        chk("busy_in_check", 64'(busy_o), 64'd1);
        @(negedge clk);
        if (ok) begin
            chk("done_pulse", 64'(done_o), 64'd1);
            chk("busy_fall_with_done", 64'(busy_o), 64'd0);
            chk("nonce", 64'(nonce_o), 64'(n));
            chk("corrected", 64'(corrected_o), 64'(corr));
            chk("err_mismatch_clear", 64'(err_mismatch_o), 64'd0);
            chk("err_timeout_clear", 64'(err_timeout_o), 64'd0);
            exp_nonce = n;
            if (late_start) begin
                start_i = 1'b1;
                block_i = rand_block();
            end
        end else begin
            chk("no_done_on_mismatch", 64'(done_o), 64'd0);
            chk("err_mismatch_set", 64'(err_mismatch_o), 64'd1);
            chk("nonce_kept", 64'(nonce_o), 64'(exp_nonce));
            chk("busy_after_mismatch", 64'(busy_o), 64'd0);
        end
        @(negedge clk);
        start_i = 1'b0;
        chk("done_single_cycle", 64'(done_o), 64'd0);
        chk("idle_after_job", 64'(busy_o), 64'd0);
        chk("no_dv_after_job", 64'(tx_dv_o), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_i = 1'b0; start_i = 1'b0; block_i = '0; rx_dv_i = 1'b0; rx_byte_i = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'({tx_dv_o, tx_byte_o}), 64'd0);
        chk("rst_busy_done", 64'({busy_o, done_o}), 64'd0);
        chk("rst_nonce", 64'(nonce_o), 64'd0);
        chk("rst_flags", 64'({corrected_o, err_mismatch_o, err_timeout_o}), 64'd0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 64'({tx_dv_o, busy_o, done_o}), 64'd0);

        // Incrementing header, clean 0xDEADBEEF reply, start in DONE ignored.
        for (int i = 0; i < BB; i++) blk[8*i +: 8] = 8'(i);
        do_send(blk, 1'b0, 1'b0);
        mk_reply(32'hDEADBEEF, rep);
        send_reply(rep, 16);
        check_result(rep, 1'b1);
        chk("nonce_deadbeef", 64'(nonce_o), 64'hDEADBEEF);

        // Noise during send, ignored restart, one corrupted copy in byte 2.
        do_send(rand_block(), 1'b1, 1'b1);
        mk_reply(32'hDEADBEEF, rep);
        rep[10] = 8'h00;
        send_reply(rep, 16);
        check_result(rep, 1'b0);
        chk("corrected_set", 64'(corrected_o), 64'd1);

        // No majority in byte 1.
        do_send(rand_block(), 1'b0, 1'b0);
        mk_reply(32'h12345678, rep);
        rep[4] = 8'hBE; rep[5] = 8'hBE; rep[6] = 8'h00; rep[7] = 8'h11;
        send_reply(rep, 16);
        check_result(rep, 1'b0);
        chk("mismatch_sticky", 64'(err_mismatch_o), 64'd1);
        chk("nonce_still_deadbeef", 64'(nonce_o), 64'hDEADBEEF);

        // Short reply: timeout after TO idle cycles.
        do_send(rand_block(), 1'b0, 1'b0);
        mk_reply($urandom, rep);
        send_reply(rep, 5);
        repeat (TO - 1) @(negedge clk);
        chk("timeout_not_yet", 64'(err_timeout_o), 64'd0);
        chk("busy_before_timeout", 64'(busy_o), 64'd1);
        @(negedge clk);
        chk("timeout_set", 64'(err_timeout_o), 64'd1);
        chk("idle_after_timeout", 64'({busy_o, done_o}), 64'd0);
        chk("nonce_after_timeout", 64'(nonce_o), 64'(exp_nonce));

        // Random nonces with random corruption per group.
        for (int t = 0; t < 5; t++) begin
            do_send(rand_block(), 1'($urandom_range(0, 1)), 1'b0);
            mk_reply($urandom, rep);
            for (int g = 0; g < 4; g++) begin
                int mode = $urandom_range(0, 3);
                int c0 = $urandom_range(0, 3);
                if (mode != 0) rep[4*g+c0] = rep[4*g+c0] ^ 8'($urandom_range(1, 255));
                if (mode == 2) rep[4*g+((c0+1)%4)] = rep[4*g+((c0+1)%4)] ^ 8'($urandom_range(1, 255));
            end
            send_reply(rep, 16);
            check_result(rep, 1'($urandom_range(0, 1)));
        end

        // Reset while byte 30 is being strobed, then a fresh job.
        blk = rand_block();
        while (resp_busy || busy_o) @(negedge clk);
        start_i = 1'b1;
        block_i = blk;
        @(negedge clk);
        start_i = 1'b0;
        k = 0;
        for (int c = 0; c < 3000; c++) begin
            if (tx_dv_o === 1'b1) k++;
            if (k == 31) break;
            @(negedge clk);
        end
        chk("reached_byte30", 64'(k), 64'd31);
        #1 rst_i = 1'b0;
        #1;
        chk("rst_async_dv", 64'(tx_dv_o), 64'd0);
        chk("rst_async_busy", 64'(busy_o), 64'd0);
        chk("rst_async_nonce", 64'(nonce_o), 64'd0);
        exp_nonce = 32'd0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        do_send(rand_block(), 1'b0, 1'b0);
        mk_reply($urandom, rep);
        send_reply(rep, 16);
        check_result(rep, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
